act_requant_unit: RTL and testbench
===================================

Name: act_requant_unit

Overview:
- Parametrised successor to the single-lane ReLU.
- Takes LANES signed accumulator values per beat and requantises each one: rounding arithmetic right shift, then a selectable activation, then saturation to OUT_WIDTH.
- Sits between the weight-stationary array's accumulator drain and the next layer's input buffer.
- Two-stage pipeline with a valid/ready handshake on both sides, plus a sticky saturation flag.

Parameters:
- IN_WIDTH, 24: signed accumulator width per lane.
- OUT_WIDTH, 8: signed output width per lane.
- LANES, 4: parallel lanes per beat.
- SHIFT_WIDTH, 5: width of the requant shift field; legal shift values are 0..IN_WIDTH-1.
- LEAK_SHIFT, 3: leaky-ReLU negative slope is 2^-LEAK_SHIFT.

Ports:
- clk  input  1  clock
- nrst  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in_data  input  LANES*IN_WIDTH  packed signed lanes; lane 0 in the LSBs
- mode_i  input  2  0=identity, 1=ReLU, 2=leaky ReLU, 3=clamped ReLU; sampled with the beat
- shift_i  input  SHIFT_WIDTH  requant right-shift amount; sampled with the beat
- clip_i  input  OUT_WIDTH-1  unsigned upper bound for mode 3; sampled with the beat
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  LANES*OUT_WIDTH  packed signed results; lane 0 in the LSBs
- sat_flag  output  1  sticky: some lane saturated since the last clear
- sat_clr  input  1  synchronous clear of sat_flag

Behaviour:
- Reset (nrst low, asynchronous): both stage valids=0, out_valid=0, out_data=0, sat_flag=0.
  - in_ready=1 once reset is released.
  - Beats in flight are dropped.
- Handshake:
  - A transfer occurs when valid&ready are both high at a clk edge.
  - While out_valid is high and out_ready is low, out_data and out_valid hold stable.
- Pipeline:
  - Stage S1 registers the shifted value; stage S2 registers the final result. S2 drives out_valid/out_data.
  - S2 loads when it is empty or out_ready=1.
  - S1 loads when it is empty or S2 loads.
  - in_ready = ~S1_valid | S2 load enable. This is combinational from out_ready; no combinational path from in_valid to in_ready.
  - Latency: an accepted beat appears on out_valid on the 2nd clk edge after acceptance.
  - Throughput: 1 beat/cycle with out_ready held high.
  - With out_ready low, at most 2 beats are buffered, then in_ready=0.
- S1 arithmetic, per lane, at IN_WIDTH+1 bits:
  - y = (x + r) >>> s, where s=shift_i.
  - r = 2^(s-1) if s>0, else 0. This rounds half toward +inf.
  - The extra bit prevents overflow when adding r.
  - mode_i and clip_i travel with the beat.
- S2 activation, per lane:
  - mode 0: a=y.
  - mode 1: a = y<0 ? 0 : y.
  - mode 2: a = y<0 ? y>>>LEAK_SHIFT : y. The shift floors, so -1 stays -1.
  - mode 3: a = y<0 ? 0 : min(y, clip_i). clip_i=0 yields all zeros.
- S2 saturation:
  - a is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - The lane's sat bit = 1 when the clamp changed the value.
  - Mode-3 clipping by clip_i is not saturation.
- sat_flag:
  - Set on the edge at which S2 loads a beat with any lane sat bit=1.
  - sat_clr clears it; if set and clear occur in the same cycle, set wins.
- Lanes are fully independent and share the same mode/shift/clip per beat.
- shift_i >= IN_WIDTH is illegal. The result is undefined, but it must not hang the handshake.

Test Plan:
- Reset with in_valid=1 asserted, then release -> out_valid=0, sat_flag=0, in_ready=1 from the first cycle after release.
- Mode 1, shift 4, lanes {100, -100, 7, 8}, out_ready=1 -> out_valid 2 cycles after acceptance, lanes {6, 0, 0, 1} (100+8=108>>>4=6; 7+8=15>>>4=0; 8+8=16>>>4=1).
- Mode 2, shift 0, lanes {-64, -1, 300, -2000} -> {-8, -1, 127, -128}; sat_flag rises on the S2 load edge (lanes 2 and 3 saturate).
- Mode 3, clip_i=6, shift 2, lanes {40, 20, -4, 1} -> {6, 5, 0, 0}; sat_flag unchanged.
- Back-to-back 8 beats with out_ready toggling 1,0,0,1,... -> all 8 beats delivered in order, none lost or duplicated; out_data stable while stalled; in_ready=0 only when S1 and S2 are full and out_ready=0.
- sat_clr pulsed in the same cycle as a saturating S2 load -> sat_flag stays 1; a later sat_clr pulse with no saturation -> sat_flag=0 next cycle.

Source files
------------

// File: rtl/act_requant_unit.sv
// act_requant_unit: multi-lane activation requantiser.
// Each beat carries LANES signed accumulator values. Each value goes through a
// rounding arithmetic right shift (stage S1), then a selectable activation and
// saturation to OUT_WIDTH (stage S2). Both sides use a valid/ready handshake.
// Saturation events are collected in a sticky flag.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   in_valid / in_ready  input beat handshake (in_ready depends combinationally on out_ready)
//   in_data              LANES x IN_WIDTH packed signed accumulators, lane 0 in the LSBs
//   mode_i               0 identity, 1 ReLU, 2 leaky ReLU, 3 clamped ReLU (sampled with the beat)
//   shift_i              requant right-shift amount (sampled with the beat)
//   clip_i               unsigned upper bound used by mode 3 (sampled with the beat)
//   out_valid/out_ready  output beat handshake
//   out_data             LANES x OUT_WIDTH packed signed results, lane 0 in the LSBs
//   sat_flag             sticky: some lane saturated since the last clear
//   sat_clr              synchronous clear of sat_flag; a coincident set wins
module act_requant_unit #(
    parameter int unsigned IN_WIDTH    = 24,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned LANES       = 4,
    parameter int unsigned SHIFT_WIDTH = 5,
    parameter int unsigned LEAK_SHIFT  = 3
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*IN_WIDTH-1:0]      in_data,
    input  logic [1:0]                     mode_i,
    input  logic [SHIFT_WIDTH-1:0]         shift_i,
    input  logic [OUT_WIDTH-2:0]           clip_i,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*OUT_WIDTH-1:0]     out_data,
    output logic                           sat_flag,
    input  logic                           sat_clr
);

    // One extra bit so that adding the rounding constant can never overflow.
    localparam int unsigned EXT_W = IN_WIDTH + 1;

    localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] OUT_MIN = EXT_W'(-(1 << (OUT_WIDTH - 1)));

    localparam logic [1:0] MODE_IDENT = 2'd0;
    localparam logic [1:0] MODE_RELU  = 2'd1;
    localparam logic [1:0] MODE_LEAKY = 2'd2;

    // S1 state: shifted lanes plus the per-beat controls that travel with them.
    logic                          s1_valid;
    logic [1:0]                    s1_mode;
    logic [OUT_WIDTH-2:0]          s1_clip;
    logic signed [EXT_W-1:0]       s1_y [LANES];

    // Handshake enables.
    logic                          s1_load;
    logic                          s2_load;

    // S1 combinational datapath.
    logic signed [EXT_W-1:0]       rnd;
    logic signed [EXT_W-1:0]       lane_x   [LANES];
    logic signed [EXT_W-1:0]       lane_sum [LANES];
    logic signed [EXT_W-1:0]       y_nxt    [LANES];

    // S2 combinational datapath.
    logic signed [EXT_W-1:0]       clip_ext;
    logic signed [EXT_W-1:0]       act      [LANES];
    logic [LANES-1:0]              lane_sat;
    logic [LANES*OUT_WIDTH-1:0]    res_nxt;

    // S2 advances when empty or drained; S1 advances when empty or S2 takes its beat.
    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;

    // Rounding shift: add half an output LSB, then shift arithmetically (round half up).
    always_comb begin
        rnd = '0;
        if (shift_i != '0) begin
            rnd = EXT_W'(1) << (shift_i - SHIFT_WIDTH'(1));
        end
        for (int i = 0; i < int'(LANES); i++) begin
            lane_x[i]   = {in_data[i*IN_WIDTH + IN_WIDTH - 1], in_data[i*IN_WIDTH +: IN_WIDTH]};
            lane_sum[i] = lane_x[i] + rnd;
            y_nxt[i]    = lane_sum[i] >>> shift_i;
        end
    end

    // Activation followed by saturation to the signed output range.
    always_comb begin
        clip_ext = EXT_W'(s1_clip);
        lane_sat = '0;
        res_nxt  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            act[i] = s1_y[i];
            case (s1_mode)
                MODE_IDENT: act[i] = s1_y[i];
                MODE_RELU:  act[i] = s1_y[i][EXT_W-1] ? '0 : s1_y[i];
                MODE_LEAKY: act[i] = s1_y[i][EXT_W-1] ? (s1_y[i] >>> LEAK_SHIFT) : s1_y[i];
                // Clamped ReLU: clip_i < 2^(OUT_WIDTH-1), so this path never saturates.
                default:    act[i] = s1_y[i][EXT_W-1] ? '0
                                   : ((s1_y[i] > clip_ext) ? clip_ext : s1_y[i]);
            endcase

            if (act[i] > OUT_MAX) begin
                res_nxt[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
                lane_sat[i]                       = 1'b1;
            end else if (act[i] < OUT_MIN) begin
                res_nxt[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
                lane_sat[i]                       = 1'b1;
            end else begin
                res_nxt[i*OUT_WIDTH +: OUT_WIDTH] = act[i][OUT_WIDTH-1:0];
            end
        end
    end

    // Stage S1 registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid <= 1'b0;
            s1_mode  <= '0;
            s1_clip  <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                s1_y[i] <= '0;
            end
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= mode_i;
                s1_clip <= clip_i;
                for (int i = 0; i < int'(LANES); i++) begin
                    s1_y[i] <= y_nxt[i];
                end
            end
        end
    end

    // Stage S2 registers: output beat holds while stalled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res_nxt;
            end
        end
    end

    // Sticky saturation flag; a saturating load beats a coincident clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sat_flag <= 1'b0;
        end else if (s2_load && s1_valid && (|lane_sat)) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_act_requant_unit.sv
// Bench for act_requant_unit: directed beats from the test plan plus randomized
// traffic with random back-pressure, all compared against a reference model.
module tb_act_requant_unit;

    localparam int IN_W  = 24;
    localparam int OUT_W = 8;
    localparam int LANES = 4;
    localparam int SW    = 5;
    localparam int LEAK  = 3;

    logic                     clk;
    logic                     nrst;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*IN_W-1:0]    in_data;
    logic [1:0]               mode_i;
    logic [SW-1:0]            shift_i;
    logic [OUT_W-2:0]         clip_i;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_data;
    logic                     sat_flag;
    logic                     sat_clr;

    act_requant_unit #(
        .IN_WIDTH    (IN_W),
        .OUT_WIDTH   (OUT_W),
        .LANES       (LANES),
        .SHIFT_WIDTH (SW),
        .LEAK_SHIFT  (LEAK)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode_i    (mode_i),
        .shift_i   (shift_i),
        .clip_i    (clip_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .sat_clr   (sat_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        bit                     sat;
        int                     id;
        int                     acc;
    } beat_t;

    beat_t                  q[$];
    int                     n_checks    = 0;
    int                     n_errs      = 0;
    int                     edge_cnt    = 0;
    int                     next_id     = 0;
    int                     last_loaded = -1;
    int                     n_delivered = 0;
    bit                     sat_m       = 1'b0;
    bit                     prev_stall  = 1'b0;
    logic [LANES*OUT_W-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on wide integers, straight from the lane rules.
    function automatic void ref_beat(input logic [LANES*IN_W-1:0] din, input logic [1:0] mode,
                                     input int s, input int clip,
                                     output logic [LANES*OUT_W-1:0] dout, output bit sat);
        longint omax;
        longint omin;
        omax = (longint'(1) <<< (OUT_W - 1)) - 1;
        omin = -(longint'(1) <<< (OUT_W - 1));
        dout = '0;
        sat  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            logic [IN_W-1:0] raw;
            longint x;
            longint y;
            longint a;
            raw = din[i*IN_W +: IN_W];
            x   = longint'($signed(raw));
            if (s > 0) y = (x + (longint'(1) <<< (s - 1))) >>> s;
            else       y = x;
            case (mode)
                2'd0:    a = y;
                2'd1:    a = (y < 0) ? 0 : y;
                2'd2:    a = (y < 0) ? (y >>> LEAK) : y;
                default: a = (y < 0) ? 0 : ((y > clip) ? longint'(clip) : y);
            endcase
            if (a > omax) begin
                a   = omax;
                sat = 1'b1;
            end else if (a < omin) begin
                a   = omin;
                sat = 1'b1;
            end
            dout[i*OUT_W +: OUT_W] = a[OUT_W-1:0];
        end
    endfunction

    function automatic logic [LANES*IN_W-1:0] pk_in(input int l0, input int l1, input int l2, input int l3);
        int v[4];
        logic [LANES*IN_W-1:0] r;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = v[i][IN_W-1:0];
        return r;
    endfunction

    function automatic logic [LANES*OUT_W-1:0] pk_out(input int l0, input int l1, input int l2, input int l3);
        int v[4];
        logic [LANES*OUT_W-1:0] r;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*OUT_W +: OUT_W] = v[i][OUT_W-1:0];
        return r;
    endfunction

    task automatic rand_beat();
        logic [LANES*IN_W-1:0] d;
        for (int i = 0; i < LANES; i++) begin
            int v;
            if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 8191)) - 4096;
            else                           v = int'($urandom);
            d[i*IN_W +: IN_W] = v[IN_W-1:0];
        end
        in_data = d;
        mode_i  = 2'($urandom_range(0, 3));
        shift_i = ($urandom_range(0, 1) == 0) ? SW'($urandom_range(0, 8)) : SW'($urandom_range(0, IN_W - 1));
        clip_i  = (OUT_W-1)'($urandom);
    endtask

    // One clock cycle: inputs already driven at posedge+1; checks mid-cycle and after the edge.
    task automatic do_cycle(output bit acc);
        bit                     del;
        bit                     msat;
        logic [LANES*OUT_W-1:0] mdata;
        beat_t                  b;
        #3;
        check("in_ready", in_ready, (q.size() < 2) || out_ready);
        check("out_valid", out_valid, (q.size() > 0) && (q[0].acc < edge_cnt));
        if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, prev_data);
        end
        acc = in_valid && in_ready;
        del = out_valid && out_ready;
        if (acc) ref_beat(in_data, mode_i, int'(shift_i), int'(clip_i), mdata, msat);
        if (del) begin
            if (q.size() == 0) check("spurious_beat", 1'b1, 1'b0);
            else               check("out_data", out_data, q[0].data);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        @(posedge clk);
        edge_cnt++;
        if (del && q.size() > 0) begin
            void'(q.pop_front());
            n_delivered++;
        end
        if (acc) begin
            b.data = mdata; b.sat = msat; b.id = next_id; b.acc = edge_cnt;
            next_id++;
            q.push_back(b);
        end
        // Oldest beat becomes visible at the edge it reaches the output register.
        if (q.size() > 0 && q[0].acc < edge_cnt && q[0].id != last_loaded) begin
            last_loaded = q[0].id;
            if (q[0].sat)    sat_m = 1'b1;
            else if (sat_clr) sat_m = 1'b0;
        end else if (sat_clr) begin
            sat_m = 1'b0;
        end
        #1;
        check("sat_flag", sat_flag, sat_m);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) do_cycle(acc);
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit acc;
        bit hold;
        bit pat[4];
        int n_acc;
        int start_del;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        nrst      = 1'b0;
        in_valid  = 1'b1;
        in_data   = pk_in(1, 2, 3, 4);
        mode_i    = 2'd0;
        shift_i   = '0;
        clip_i    = '0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;

        // Reset with a beat offered.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sat_flag", sat_flag, 1'b0);
        check("rst_out_data", out_data, '0);
        nrst     = 1'b1;
        in_valid = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);

        // Mode 1 (ReLU), shift 4.
        in_valid = 1'b1; in_data = pk_in(100, -100, 7, 8); mode_i = 2'd1; shift_i = 5'd4;
        do_cycle(acc);
        check("m1_accept", acc, 1'b1);
        in_valid = 1'b0;
        check("m1_lat_edge1", out_valid, 1'b0);
        do_cycle(acc);
        check("m1_lat_edge2", out_valid, 1'b1);
        check("m1_data", out_data, pk_out(6, 0, 0, 1));
        do_cycle(acc);

        // Mode 2 (leaky), shift 0, two lanes saturate.
        in_valid = 1'b1; in_data = pk_in(-64, -1, 300, -2000); mode_i = 2'd2; shift_i = 5'd0;
        do_cycle(acc);
        in_valid = 1'b0;
        check("m2_sat_before", sat_flag, 1'b0);
        do_cycle(acc);
        check("m2_data", out_data, pk_out(-8, -1, 127, -128));
        check("m2_sat_rise", sat_flag, 1'b1);
        do_cycle(acc);

        // Mode 3 (clamped), clip 6, shift 2: clipping is not saturation.
        in_valid = 1'b1; in_data = pk_in(40, 20, -4, 1); mode_i = 2'd3; shift_i = 5'd2; clip_i = 7'd6;
        do_cycle(acc);
        in_valid = 1'b0;
        do_cycle(acc);
        check("m3_data", out_data, pk_out(6, 5, 0, 0));
        check("m3_sat_kept", sat_flag, 1'b1);
        do_cycle(acc);

        // Eight back-to-back beats with out_ready pattern 1,0,0,1.
        n_acc     = 0;
        start_del = n_delivered;
        hold      = 1'b0;
        for (int c = 0; c < 100 && n_acc < 8; c++) begin
            in_valid = 1'b1;
            if (!hold) rand_beat();
            out_ready = pat[c % 4];
            do_cycle(acc);
            hold = !acc;
            if (acc) n_acc++;
        end
        check("b2b_accepted", n_acc, 8);
        drain();
        check("b2b_delivered", n_delivered - start_del, 8);

        // Clear racing a saturating load, then a plain clear.
        sat_clr = 1'b1;
        do_cycle(acc);
        check("clr_idle", sat_flag, 1'b0);
        sat_clr = 1'b0;
        in_valid = 1'b1; in_data = pk_in(300, 0, 0, 0); mode_i = 2'd0; shift_i = 5'd0;
        do_cycle(acc);
        in_valid = 1'b0;
        sat_clr  = 1'b1;
        do_cycle(acc);
        check("clr_vs_set", sat_flag, 1'b1);
        sat_clr = 1'b0;
        do_cycle(acc);
        sat_clr = 1'b1;
        do_cycle(acc);
        check("clr_later", sat_flag, 1'b0);
        sat_clr = 1'b0;

        // Reset with beats in flight drops them.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = pk_in(-5000, 9, 300, 1); mode_i = 2'd0; shift_i = 5'd0;
        do_cycle(acc);
        do_cycle(acc);
        nrst = 1'b0;
        #3;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_sat_flag", sat_flag, 1'b0);
        q.delete();
        sat_m      = 1'b0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        nrst      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        do_cycle(acc);
        do_cycle(acc);

        // Randomized traffic with back-pressure and occasional clears.
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_beat();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr   = ($urandom_range(0, 9) == 0);
            do_cycle(acc);
            hold = in_valid && !acc;
        end
        sat_clr = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
